// File: rtl/load_align_unit.sv
// Load data aligner: issues one or two word-aligned reads per load request, then
// shifts, masks and sign/zero-extends the bytes into an XLEN result.
module load_align_unit #(
    parameter int XLEN           = 32,
    parameter int ADDR_W         = 32,
    parameter int ALLOW_MISALIGN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_func3,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [XLEN-1:0]   mem_resp_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_data,
    output logic              resp_fault
);
    localparam int BYTES = XLEN / 8;
    localparam int OFFW  = $clog2(BYTES);

    typedef enum logic [2:0] {IDLE, REQ0, RSP0, REQ1, RSP1, DONE} state_t;

    state_t            state;
    logic [OFFW-1:0]   off_q;
    logic [2:0]        func3_q;
    logic [XLEN-1:0]   beat0;

    // Incoming request decode
    logic       in_illegal;
    logic       in_misalign;
    logic       in_fault;
    logic [3:0] in_mask;

    always_comb begin
        in_mask     = (4'd1 << req_func3[1:0]) - 4'd1;
        in_illegal  = (req_func3 == 3'b111) ||
                      ((XLEN == 32) && ((req_func3 == 3'b011) || (req_func3 == 3'b110)));
        in_misalign = (req_addr[2:0] & in_mask[2:0]) != 3'd0;
        in_fault    = in_illegal || (in_misalign && (ALLOW_MISALIGN == 0));
    end

    // Split decision from the latched offset and size
    logic [4:0] off_sum;
    logic       split;

    always_comb begin
        off_sum = 5'(off_q) + (5'd1 << func3_q[1:0]);
        split   = off_sum > 5'(BYTES);
    end

    // Extraction: beat1 comes straight off the bus when finishing a split access
    logic [2*XLEN-1:0] pair;
    logic [XLEN-1:0]   raw;
    logic [XLEN-1:0]   mask;
    logic              msb;
    logic [XLEN-1:0]   result;

    always_comb begin
        pair = (state == RSP1) ? {mem_resp_data, beat0} : {{XLEN{1'b0}}, mem_resp_data};
        raw  = XLEN'(pair >> {off_q, 3'b000});
        case (func3_q[1:0])
            2'd0: begin mask = XLEN'(8'hFF);         msb = raw[7];      end
            2'd1: begin mask = XLEN'(16'hFFFF);      msb = raw[15];     end
            2'd2: begin mask = XLEN'(32'hFFFF_FFFF); msb = raw[31];     end
            default: begin mask = '1;                msb = raw[XLEN-1]; end
        endcase
        result = (raw & mask) | ((msb && !func3_q[2]) ? ~mask : '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            off_q         <= '0;
            func3_q       <= '0;
            beat0         <= '0;
            req_ready     <= 1'b1;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            resp_valid    <= 1'b0;
            resp_data     <= '0;
            resp_fault    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    off_q     <= req_addr[OFFW-1:0];
                    func3_q   <= req_func3;
                    req_ready <= 1'b0;
                    if (in_fault) begin
                        state      <= DONE;
                        resp_valid <= 1'b1;
                        resp_data  <= '0;
                        resp_fault <= 1'b1;
                    end else begin
                        state         <= REQ0;
                        mem_req_valid <= 1'b1;
                        mem_req_addr  <= {req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
                    end
                end
                REQ0: if (mem_req_ready) begin
                    mem_req_valid <= 1'b0;
                    state         <= RSP0;
                end
                RSP0: if (mem_resp_valid) begin
                    beat0 <= mem_resp_data;
                    if (split) begin
                        state         <= REQ1;
                        mem_req_valid <= 1'b1;
                        mem_req_addr  <= mem_req_addr + ADDR_W'(BYTES);
                    end else begin
                        state      <= DONE;
                        resp_valid <= 1'b1;
                        resp_data  <= result;
                        resp_fault <= 1'b0;
                    end
                end
                REQ1: if (mem_req_ready) begin
                    mem_req_valid <= 1'b0;
                    state         <= RSP1;
                end
                RSP1: if (mem_resp_valid) begin
                    state      <= DONE;
                    resp_valid <= 1'b1;
                    resp_data  <= result;
                    resp_fault <= 1'b0;
                end
                DONE: if (resp_ready) begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_align_unit.sv
// Bench for load_align_unit: three configurations share a byte-addressed memory model;
// expected results come from the load rules applied to that byte array.
module tb_load_align_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid[3], req_ready[3], mem_req_valid[3], mem_req_ready[3];
  logic        mem_resp_valid[3], resp_valid[3], resp_ready[3], resp_fault[3];
  logic [31:0] req_addr[3], mem_req_addr[3];
  logic [2:0]  req_func3[3];
  logic [63:0] mdata[3], rdata[3];

  // g=0: XLEN32 misalign ok; g=1: XLEN64 misalign ok; g=2: XLEN32 misalign faults
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int XL = (g == 1) ? 64 : 32;
    localparam int AM = (g == 2) ? 0 : 1;
    logic [XL-1:0] rd_loc, md_loc;
    assign md_loc   = mdata[g][XL-1:0];
    assign rdata[g] = 64'(rd_loc);
    load_align_unit #(.XLEN(XL), .ADDR_W(32), .ALLOW_MISALIGN(AM)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]),
      .req_addr(req_addr[g]), .req_func3(req_func3[g]),
      .mem_req_valid(mem_req_valid[g]), .mem_req_ready(mem_req_ready[g]),
      .mem_req_addr(mem_req_addr[g]),
      .mem_resp_valid(mem_resp_valid[g]), .mem_resp_data(md_loc),
      .resp_valid(resp_valid[g]), .resp_ready(resp_ready[g]),
      .resp_data(rd_loc), .resp_fault(resp_fault[g])
    );
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  logic [7:0] mem [logic [31:0]];

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  task automatic wr_word(input logic [31:0] a, input logic [63:0] w, input int nb);
    for (int k = 0; k < nb; k++) mem[a + 32'(k)] = w[8*k +: 8];
  endtask

  function automatic logic [63:0] word_at(input logic [31:0] a, input int nb);
    logic [63:0] w = '0;
    for (int k = 0; k < nb; k++) w |= 64'(rd_byte(a + 32'(k))) << (8*k);
    return w;
  endfunction

  // Per-cycle expectations for the selected instance, checked on every falling edge
  int          sel = 0;
  logic        chk_en = 1'b0;
  logic        e_rr = 1'b1, e_mrv = 1'b0, e_rv = 1'b0, e_rf = 1'b0;
  logic [31:0] e_mra = '0;
  logic [63:0] e_rd = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", 64'(req_ready[sel]), 64'(e_rr));
      chk("mem_req_valid", 64'(mem_req_valid[sel]), 64'(e_mrv));
      if (e_mrv) chk("mem_req_addr", 64'(mem_req_addr[sel]), 64'(e_mra));
      chk("resp_valid", 64'(resp_valid[sel]), 64'(e_rv));
      if (e_rv) begin
        chk("resp_data", rdata[sel], e_rd);
        chk("resp_fault", 64'(resp_fault[sel]), 64'(e_rf));
      end
    end
  end

  task automatic set_idle();
    e_rr = 1'b1; e_mrv = 1'b0; e_rv = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run_txn(input int g, input logic [31:0] addr, input logic [2:0] f3,
                         input int lat, input int stall, input int hold,
                         input logic use_lit, input logic [63:0] lit, input logic rst_in_rsp1);
    int xl, nb, size;
    logic illegal, fault, split;
    logic [63:0] val, mask;
    logic [31:0] base;
    xl = (g == 1) ? 64 : 32;
    nb = xl / 8;
    size = 1 << f3[1:0];
    illegal = (f3 == 3'b111) || (xl == 32 && (f3 == 3'b011 || f3 == 3'b110));
    fault = illegal || ((addr % size) != 0 && g == 2);
    split = (int'(addr % nb) + size) > nb;
    val = '0;
    for (int k = 0; k < size; k++) val |= 64'(rd_byte(addr + 32'(k))) << (8*k);
    mask = (size == 8) ? '1 : (64'(1) << (8*size)) - 64'd1;
    if (!f3[2] && val[8*size-1]) val |= ~mask;
    if (xl == 32) val &= 64'hFFFF_FFFF;
    if (fault) val = '0;
    base = addr & ~32'(nb - 1);

    sel = g; set_idle();
    req_valid[g] = 1'b1; req_addr[g] = addr; req_func3[g] = f3;
    tick();
    req_valid[g] = 1'b0; e_rr = 1'b0;
    if (!fault) begin
      for (int b = 0; b < (split ? 2 : 1); b++) begin
        e_mrv = 1'b1; e_mra = base + 32'(b * nb);
        for (int s = 0; s <= stall; s++) begin
          mem_req_ready[g] = (s == stall);
          tick();
        end
        mem_req_ready[g] = 1'b0; e_mrv = 1'b0;
        if (rst_in_rsp1 && b == 1) begin
          rst_n = 1'b0;
          tick();
          set_idle();
          chk("rst_mem_req_addr", 64'(mem_req_addr[g]), 64'd0);
          chk("rst_resp_data", rdata[g], 64'd0);
          chk("rst_resp_fault", 64'(resp_fault[g]), 64'd0);
          rst_n = 1'b1;
          mem_resp_valid[g] = 1'b1; mdata[g] = word_at(e_mra, nb);
          tick();
          mem_resp_valid[g] = 1'b0;
          repeat (3) tick();
          return;
        end
        for (int w = 0; w < lat; w++) tick();
        mem_resp_valid[g] = 1'b1; mdata[g] = word_at(e_mra, nb);
        tick();
        mem_resp_valid[g] = 1'b0;
      end
    end
    e_rv = 1'b1; e_rd = val; e_rf = fault;
    if (use_lit) chk("literal", rdata[g], lit);
    // Stray request and memory response while the result waits must be ignored
    for (int h = 0; h < hold; h++) begin
      req_valid[g] = 1'b1; req_addr[g] = 32'hDEAD_0000;
      mem_resp_valid[g] = 1'b1; mdata[g] = '1;
      tick();
    end
    req_valid[g] = 1'b0; mem_resp_valid[g] = 1'b0;
    resp_ready[g] = 1'b1;
    tick();
    resp_ready[g] = 1'b0;
    set_idle();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 1'b0; req_addr[i] = '0; req_func3[i] = '0;
      mem_req_ready[i] = 1'b0; mem_resp_valid[i] = 1'b0; mdata[i] = '0; resp_ready[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset_req_ready", 64'(req_ready[i]), 64'd1);
      chk("reset_mem_req_valid", 64'(mem_req_valid[i]), 64'd0);
      chk("reset_mem_req_addr", 64'(mem_req_addr[i]), 64'd0);
      chk("reset_resp_valid", 64'(resp_valid[i]), 64'd0);
      chk("reset_resp_data", rdata[i], 64'd0);
      chk("reset_resp_fault", 64'(resp_fault[i]), 64'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;

    // XLEN=32, misalign allowed
    wr_word(32'h100, 64'h80FF_1234, 4);
    run_txn(0, 32'h103, 3'b000, 0, 0, 5, 1'b1, 64'hFFFF_FF80, 1'b0);
    run_txn(0, 32'h102, 3'b001, 1, 0, 0, 1'b1, 64'hFFFF_80FF, 1'b0);
    wr_word(32'h100, 64'hAB00_0000, 4);
    wr_word(32'h104, 64'h0000_00CD, 4);
    run_txn(0, 32'h103, 3'b101, 1, 0, 0, 1'b1, 64'h0000_CDAB, 1'b0);
    run_txn(0, 32'h101, 3'b010, 2, 1, 1, 1'b1, 64'hCDAB_0000, 1'b0);
    wr_word(32'hFFFF_FFFC, 64'h7F00_0000, 4);
    wr_word(32'h0, 64'h0000_00F1, 4);
    run_txn(0, 32'hFFFF_FFFF, 3'b001, 0, 0, 0, 1'b1, 64'hFFFF_F17F, 1'b0);
    run_txn(0, 32'h0, 3'b011, 0, 0, 2, 1'b1, 64'h0, 1'b0);
    run_txn(0, 32'h4, 3'b111, 0, 0, 0, 1'b1, 64'h0, 1'b0);
    run_txn(0, 32'h8, 3'b110, 0, 0, 0, 1'b1, 64'h0, 1'b0);

    // XLEN=64
    wr_word(32'h1000, 64'h1122_3344_5566_7788, 8);
    wr_word(32'h1008, 64'h99AA_BBCC_DDEE_FF00, 8);
    run_txn(1, 32'h1006, 3'b010, 1, 0, 0, 1'b1, 64'hFFFF_FFFF_FF00_1122, 1'b0);
    run_txn(1, 32'h1006, 3'b110, 0, 0, 0, 1'b1, 64'h0000_0000_FF00_1122, 1'b0);
    run_txn(1, 32'h1003, 3'b011, 0, 1, 0, 1'b1, 64'hEEFF_0011_2233_4455, 1'b0);
    run_txn(1, 32'h1008, 3'b011, 1, 0, 0, 1'b1, 64'h99AA_BBCC_DDEE_FF00, 1'b0);
    run_txn(1, 32'h1009, 3'b100, 0, 0, 0, 1'b1, 64'h0000_0000_0000_00FF, 1'b0);
    run_txn(1, 32'h1004, 3'b001, 0, 0, 0, 1'b1, 64'h0000_0000_0000_3344, 1'b0);
    run_txn(1, 32'h1000, 3'b111, 0, 0, 0, 1'b1, 64'h0, 1'b0);

    // XLEN=32, misaligned accesses fault
    wr_word(32'h0, 64'h1234_5678, 4);
    run_txn(2, 32'h2, 3'b010, 0, 0, 0, 1'b1, 64'h0, 1'b0);
    run_txn(2, 32'h0, 3'b010, 1, 0, 0, 1'b1, 64'h1234_5678, 1'b0);
    run_txn(2, 32'h1, 3'b001, 0, 0, 0, 1'b1, 64'h0, 1'b0);
    run_txn(2, 32'h3, 3'b100, 0, 0, 0, 1'b1, 64'h0000_0012, 1'b0);
    run_txn(2, 32'h2, 3'b101, 0, 0, 0, 1'b1, 64'h0000_1234, 1'b0);

    // Reset while waiting for the second beat, then recovery
    wr_word(32'h100, 64'hAB00_0000, 4);
    wr_word(32'h104, 64'h0000_00CD, 4);
    run_txn(0, 32'h103, 3'b101, 0, 0, 0, 1'b0, 64'h0, 1'b1);
    run_txn(0, 32'h100, 3'b010, 0, 0, 0, 1'b1, 64'hAB00_0000, 1'b0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
